// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the pipelined controller:
// opcodes, ALU op / write-back select enums and the control word.
package cpu_ctrl_pkg;

  localparam int OPCODE_W_DEF = 4;
  localparam int RADDR_W_DEF  = 6;
  localparam int CNT_W_DEF    = 16;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_NEG  = 3'd2,
    ALU_INC  = 3'd3,
    ALU_PASS = 3'd4
  } aluop_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1
  } wbsel_e;

  typedef struct packed {
    aluop_e aluop;
    logic   alusrc;
    logic   brz;
    logic   brn;
    logic   jump;
    logic   jumpmem;
    logic   memread;
    logic   memwrite;
    logic   regwrt;
    wbsel_e wbctl;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> control word decoder with illegal flag.
// Ports: opcode in; ctrl (ctrl_word_t), illegal out.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          ctrl,
  output logic                illegal
);

  logic       hi;
  logic [3:0] op;

  // any bit above [3:0] makes the opcode illegal
  assign hi = (opcode >> 4) != '0;
  assign op = opcode[3:0];

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    if (hi) begin
      illegal = 1'b1;
    end else begin
      unique case (op)
        OP_NOP: ;
        OP_SVPC: begin
          ctrl.aluop  = ALU_ADD;
          ctrl.alusrc = 1'b1;
          ctrl.regwrt = 1'b1;
        end
        OP_LD: begin
          ctrl.aluop   = ALU_PASS;
          ctrl.memread = 1'b1;
          ctrl.wbctl   = WB_MEM;
          ctrl.regwrt  = 1'b1;
        end
        OP_ST: begin
          ctrl.aluop    = ALU_PASS;
          ctrl.memwrite = 1'b1;
        end
        OP_ADD: begin
          ctrl.aluop  = ALU_ADD;
          ctrl.regwrt = 1'b1;
        end
        OP_INC: begin
          ctrl.aluop  = ALU_INC;
          ctrl.alusrc = 1'b1;
          ctrl.regwrt = 1'b1;
        end
        OP_NEG: begin
          ctrl.aluop  = ALU_NEG;
          ctrl.regwrt = 1'b1;
        end
        OP_SUB: begin
          ctrl.aluop  = ALU_SUB;
          ctrl.regwrt = 1'b1;
        end
        OP_J:   ctrl.jump = 1'b1;
        OP_BRZ: ctrl.brz  = 1'b1;
        OP_JM: begin
          ctrl.jumpmem = 1'b1;
          ctrl.memread = 1'b1;
        end
        OP_BRN: ctrl.brn = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, redirect flush, external freeze, event counters.
// Ports: ID opcode/regs in, ext_stall/ex_redirect in;
//   stall_out/flush_out, per-stage controls, illegal_op, counters out.
module pipe_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int RADDR_W  = RADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               ext_stall,
  input  logic               ex_redirect,
  output logic               stall_out,
  output logic               flush_out,
  output logic               ex_valid,
  output logic [2:0]         ex_aluOp,
  output logic               ex_aluSrc,
  output logic               ex_branchZero,
  output logic               ex_branchNeg,
  output logic               ex_jump,
  output logic               ex_jumpMem,
  output logic               mem_valid,
  output logic               mem_memRead,
  output logic               mem_memWrite,
  output logic               wb_valid,
  output logic               wb_regWrt,
  output logic [1:0]         wb_writeBackControl,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef struct packed {
    logic               valid;
    ctrl_word_t         c;
    logic [RADDR_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic               valid;
    logic               memread;
    logic               memwrite;
    logic               regwrt;
    wbsel_e             wbctl;
    logic [RADDR_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic               valid;
    logic               regwrt;
    wbsel_e             wbctl;
    logic [RADDR_W-1:0] rd;
  } memwb_t;

  idex_t      ex_q, ex_d;
  exmem_t     mem_q, mem_d;
  memwb_t     wb_q, wb_d;
  ctrl_word_t dec;
  logic       dec_ill;
  logic       haz;
  logic       bubble;
  logic       haz_stall;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (id_opcode),
    .ctrl    (dec),
    .illegal (dec_ill)
  );

  assign haz = ex_q.valid & ex_q.c.memread & ex_q.c.regwrt
             & id_valid
             & (ex_q.rd == id_rs | ex_q.rd == id_rt);

  // redirect wins: a squashed slot needs no load-use stall
  assign haz_stall = haz & ~ex_redirect;
  assign bubble    = ex_redirect | haz;

  assign stall_out = ~rst & (ext_stall | haz_stall);
  assign flush_out = ~rst & ~ext_stall & ex_redirect;

  always_comb begin
    ex_d = '0;
    if (!bubble && id_valid) begin
      ex_d.valid = 1'b1;
      ex_d.c     = dec;
      ex_d.rd    = id_rd;
    end
  end

  always_comb begin
    mem_d          = '0;
    mem_d.valid    = ex_q.valid;
    mem_d.memread  = ex_q.c.memread;
    mem_d.memwrite = ex_q.c.memwrite;
    mem_d.regwrt   = ex_q.c.regwrt;
    mem_d.wbctl    = ex_q.c.wbctl;
    mem_d.rd       = ex_q.rd;
  end

  always_comb begin
    wb_d        = '0;
    wb_d.valid  = mem_q.valid;
    wb_d.regwrt = mem_q.regwrt;
    wb_d.wbctl  = mem_q.wbctl;
    wb_d.rd     = mem_q.rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (!ext_stall) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      if (id_valid && dec_ill && !bubble)
        illegal_op <= 1'b1;
      if (haz_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (ex_redirect && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_aluOp      = ex_q.c.aluop;
  assign ex_aluSrc     = ex_q.c.alusrc;
  assign ex_branchZero = ex_q.c.brz;
  assign ex_branchNeg  = ex_q.c.brn;
  assign ex_jump       = ex_q.c.jump;
  assign ex_jumpMem    = ex_q.c.jumpmem;

  assign mem_valid    = mem_q.valid;
  assign mem_memRead  = mem_q.memread;
  assign mem_memWrite = mem_q.memwrite;

  assign wb_valid            = wb_q.valid;
  assign wb_regWrt           = wb_q.regwrt;
  assign wb_writeBackControl = wb_q.wbctl;
  assign wb_rd               = wb_q.rd;

endmodule

// File: tb/tb_pipe_control.sv
// Directed-vector bench for pipe_control; a second instance
// with CNT_W=2 shares the stimulus to exercise saturation.
module tb_pipe_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [5:0] id_rs, id_rt, id_rd;
  logic       ext_stall;
  logic       ex_redirect;

  logic        stall_out, flush_out;
  logic        ex_valid, ex_aluSrc, ex_branchZero, ex_branchNeg;
  logic        ex_jump, ex_jumpMem;
  logic [2:0]  ex_aluOp;
  logic        mem_valid, mem_memRead, mem_memWrite;
  logic        wb_valid, wb_regWrt;
  logic [1:0]  wb_writeBackControl;
  logic [5:0]  wb_rd;
  logic        illegal_op;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_stall_out, s_flush_out;
  logic        s_ex_valid, s_ex_aluSrc, s_ex_branchZero, s_ex_branchNeg;
  logic        s_ex_jump, s_ex_jumpMem;
  logic [2:0]  s_ex_aluOp;
  logic        s_mem_valid, s_mem_memRead, s_mem_memWrite;
  logic        s_wb_valid, s_wb_regWrt;
  logic [1:0]  s_wb_writeBackControl;
  logic [5:0]  s_wb_rd;
  logic        s_illegal_op;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_control u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ext_stall(ext_stall),
    .ex_redirect(ex_redirect),
    .stall_out(stall_out), .flush_out(flush_out),
    .ex_valid(ex_valid), .ex_aluOp(ex_aluOp),
    .ex_aluSrc(ex_aluSrc), .ex_branchZero(ex_branchZero),
    .ex_branchNeg(ex_branchNeg), .ex_jump(ex_jump),
    .ex_jumpMem(ex_jumpMem), .mem_valid(mem_valid),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .wb_valid(wb_valid), .wb_regWrt(wb_regWrt),
    .wb_writeBackControl(wb_writeBackControl),
    .wb_rd(wb_rd), .illegal_op(illegal_op),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_control #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ext_stall(ext_stall),
    .ex_redirect(ex_redirect),
    .stall_out(s_stall_out), .flush_out(s_flush_out),
    .ex_valid(s_ex_valid), .ex_aluOp(s_ex_aluOp),
    .ex_aluSrc(s_ex_aluSrc), .ex_branchZero(s_ex_branchZero),
    .ex_branchNeg(s_ex_branchNeg), .ex_jump(s_ex_jump),
    .ex_jumpMem(s_ex_jumpMem), .mem_valid(s_mem_valid),
    .mem_memRead(s_mem_memRead), .mem_memWrite(s_mem_memWrite),
    .wb_valid(s_wb_valid), .wb_regWrt(s_wb_regWrt),
    .wb_writeBackControl(s_wb_writeBackControl),
    .wb_rd(s_wb_rd), .illegal_op(s_illegal_op),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [5:0] rs, input logic [5:0] rt,
                       input logic [5:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    ext_stall = 1'b1;
    ex_redirect = 1'b1;
    drive(1'b1, 4'b0100, 6'd1, 6'd2, 6'd3);
    #1;
    check("rst_stall_out", stall_out, 0);
    check("rst_flush_out", flush_out, 0);
    tick();
    tick();
    ext_stall = 1'b0;
    ex_redirect = 1'b0;
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_illegal", illegal_op, 0);
    rst = 1'b0;
    tick();

    // 1: ADD then SUB
    drive(1'b1, 4'b0100, 6'd1, 6'd2, 6'd3);
    tick();
    check("t1_add_valid", ex_valid, 1);
    check("t1_add_aluop", ex_aluOp, 0);
    drive(1'b1, 4'b0111, 6'd1, 6'd2, 6'd4);
    tick();
    check("t1_sub_aluop", ex_aluOp, 1);
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    tick();
    check("t1_add_wb_regwrt", wb_regWrt, 1);
    check("t1_add_wb_rd", wb_rd, 3);
    check("t1_add_wb_ctl", wb_writeBackControl, 0);
    tick();
    check("t1_sub_wb_regwrt", wb_regWrt, 1);
    check("t1_sub_wb_rd", wb_rd, 4);
    check("t1_stall_cnt", stall_cnt, 0);

    // 2: load-use
    idle(3);
    drive(1'b1, 4'b1110, 6'd0, 6'd0, 6'd5);
    #1;
    check("t2_ld_id_nostall", stall_out, 0);
    tick();
    drive(1'b1, 4'b0100, 6'd5, 6'd1, 6'd6);
    #1;
    check("t2_stall", stall_out, 1);
    check("t2_noflush", flush_out, 0);
    tick();
    check("t2_bubble_valid", ex_valid, 0);
    check("t2_ld_in_mem", mem_memRead, 1);
    check("t2_stall_drop", stall_out, 0);
    tick();
    check("t2_add_ex", ex_valid, 1);
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    tick();
    tick();
    check("t2_add_wb_valid", wb_valid, 1);
    check("t2_add_wb_regwrt", wb_regWrt, 1);
    check("t2_add_wb_rd", wb_rd, 6);
    check("t2_stall_cnt", stall_cnt, 1);

    // 3: redirect squashes ID instruction
    idle(3);
    drive(1'b1, 4'b1001, 6'd0, 6'd0, 6'd0);
    tick();
    check("t3_brz_ex", ex_branchZero, 1);
    drive(1'b1, 4'b0100, 6'd1, 6'd2, 6'd7);
    ex_redirect = 1'b1;
    #1;
    check("t3_flush", flush_out, 1);
    check("t3_nostall", stall_out, 0);
    tick();
    ex_redirect = 1'b0;
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    check("t3_ex_bubble", ex_valid, 0);
    check("t3_brz_mem", mem_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_wb_regwrt", wb_regWrt, 0);
    end
    check("t3_flush_cnt", flush_cnt, 1);
    check("t3_sat_flush_cnt", s_flush_cnt, 1);

    // 4: ext_stall freezes LD in MEM
    idle(3);
    drive(1'b1, 4'b1110, 6'd0, 6'd0, 6'd9);
    tick();
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    tick();
    check("t4_ld_mem", mem_memRead, 1);
    ext_stall = 1'b1;
    ex_redirect = 1'b1;
    #1;
    check("t4_stall_out", stall_out, 1);
    check("t4_flush_out", flush_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_memread", mem_memRead, 1);
      check("t4_hold_wb", wb_valid, 0);
    end
    check("t4_flush_cnt_hold", flush_cnt, 1);
    ext_stall = 1'b0;
    ex_redirect = 1'b0;
    tick();
    check("t4_memread_drop", mem_memRead, 0);
    check("t4_ld_wb_regwrt", wb_regWrt, 1);
    check("t4_ld_wb_ctl", wb_writeBackControl, 1);
    check("t4_ld_wb_rd", wb_rd, 9);

    // 5: illegal opcode
    idle(3);
    drive(1'b1, 4'b0001, 6'd1, 6'd2, 6'd3);
    #1;
    check("t5_illegal_pre", illegal_op, 0);
    tick();
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    check("t5_illegal", illegal_op, 1);
    check("t5_ex_aluop", ex_aluOp, 0);
    check("t5_ex_ctl", {ex_aluSrc, ex_branchZero, ex_branchNeg,
                        ex_jump, ex_jumpMem}, 0);
    tick();
    check("t5_mem_ctl", {mem_memRead, mem_memWrite}, 0);
    tick();
    check("t5_wb_regwrt", wb_regWrt, 0);
    check("t5_illegal_sticky", illegal_op, 1);

    // 6: reset mid-flight, then counter saturation
    drive(1'b1, 4'b0100, 6'd1, 6'd2, 6'd10);
    tick();
    drive(1'b1, 4'b0111, 6'd1, 6'd2, 6'd11);
    tick();
    drive(1'b1, 4'b0101, 6'd1, 6'd2, 6'd12);
    tick();
    check("t6_pre_wb", wb_regWrt, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_stall_out", stall_out, 0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    check("t6_ex_valid", ex_valid, 0);
    check("t6_mem_valid", mem_valid, 0);
    check("t6_wb_valid", wb_valid, 0);
    check("t6_wb_regwrt", wb_regWrt, 0);
    check("t6_flush_cnt", flush_cnt, 0);
    check("t6_stall_cnt", stall_cnt, 0);
    check("t6_illegal", illegal_op, 0);
    ex_redirect = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ex_redirect = 1'b0;
    check("t6_sat_flush_cnt", s_flush_cnt, 3);
    check("t6_full_flush_cnt", flush_cnt, 5);

    // redirect plus load-use: flush only
    idle(2);
    drive(1'b1, 4'b1110, 6'd0, 6'd0, 6'd5);
    tick();
    drive(1'b1, 4'b0100, 6'd5, 6'd5, 6'd6);
    ex_redirect = 1'b1;
    #1;
    check("t7_stall_out", stall_out, 0);
    check("t7_flush_out", flush_out, 1);
    tick();
    ex_redirect = 1'b0;
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0);
    check("t7_ex_bubble", ex_valid, 0);
    check("t7_stall_cnt", stall_cnt, 0);
    check("t7_flush_cnt", flush_cnt, 6);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
